// File: rtl/bcd_pkg.sv
// Shared definitions for the serial packed-BCD subtractor.
//   bcd_sub_state_t : sequencer states (IDLE, SUB, NEG)
//   BCD_DIGIT_MAX   : largest legal decimal digit
//   BCD_RADIX       : correction added to a digit that borrowed
//   bcd_digit_valid : 1 when a nibble holds a legal decimal digit
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      NEG  = 2'd2
   } bcd_sub_state_t;

   localparam int BCD_DIGIT_MAX = 9;
   localparam int BCD_RADIX     = 10;

   function automatic logic bcd_digit_valid(input logic [3:0] nibble);
      return (nibble <= 4'(BCD_DIGIT_MAX));
   endfunction

endpackage

// File: rtl/bcd_sub_digit2.sv
// Two-digit packed-BCD subtract slice: o = a - b - bin, one byte at a time.
// Ports:
//   a, b : 8-bit packed BCD operands (high digit in [7:4])
//   bin  : borrow into the low digit
//   o    : 8-bit packed BCD difference
//   bout : borrow out of the high digit
// Each digit computes d = x - y - borrow in 5 bits; bit 4 set means the
// difference went negative, in which case 10 is added back and a borrow is
// passed up. Illegal digits follow the same formula, so the result stays
// deterministic even when it is meaningless.
module bcd_sub_digit2
   import bcd_pkg::*;
(
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       bin,
   output logic [7:0] o,
   output logic       bout
);

   logic [4:0] lo_d;
   logic [4:0] hi_d;
   logic       lo_b;

   always_comb begin
      lo_d = {1'b0, a[3:0]} - {1'b0, b[3:0]} - {4'b0, bin};
      lo_b = lo_d[4];
      if (lo_b) lo_d = lo_d + 5'(BCD_RADIX);

      hi_d = {1'b0, a[7:4]} - {1'b0, b[7:4]} - {4'b0, lo_b};
      bout = hi_d[4];
      if (bout) hi_d = hi_d + 5'(BCD_RADIX);

      o = {hi_d[3:0], lo_d[3:0]};
   end

endmodule

// File: rtl/bcd_sub_seq.sv
// Byte-serial packed-BCD subtractor: o = a - b - bi over N bytes, low byte
// first, with an optional second pass that turns a negative ten's-complement
// result into its magnitude (neg=1).
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   ld            : start request, accepted only while busy=0
//   a, b, bi, sm  : operands, borrow in, sign-magnitude select (sampled on ld)
//   o             : difference, written when done pulses, held otherwise
//   bo            : borrow out of the top digit of the subtract pass
//   neg           : result was negated into sign-magnitude form
//   err           : an operand digit was >9 at ld (computation still runs)
//   busy          : state != IDLE
//   done          : one-cycle pulse, o/bo/neg valid
// Handshake: ld is a request, busy is its back-pressure. A ld seen at a clock
// edge while busy=0 starts an operation; ld while busy=1 is dropped. done
// pulses for exactly one cycle, and since busy is already 0 then, a ld in the
// done cycle starts the next operation.
module bcd_sub_seq
   import bcd_pkg::*;
#(
   parameter int N = 33
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         ld,
   input  logic [N*8-1:0] a,
   input  logic [N*8-1:0] b,
   input  logic         bi,
   input  logic         sm,
   output logic [N*8-1:0] o,
   output logic         bo,
   output logic         neg,
   output logic         err,
   output logic         busy,
   output logic         done
);

   localparam int W  = N * 8;
   localparam int CW = $clog2(N + 1);

   bcd_sub_state_t state;
   logic [W-1:0]   a_sh;
   logic [W-1:0]   b_sh;
   logic [W-1:0]   res_sh;
   logic           brw;
   logic           sm_q;
   logic [CW-1:0]  cnt;

   logic [7:0]     dx;
   logic [7:0]     dy;
   logic [7:0]     dig_o;
   logic           dig_bout;
   logic [W-1:0]   res_next;
   logic           ld_err;
   logic           last;

   // The negate pass reuses the slice as 0 - result, consuming the result
   // register from the bottom while refilling it from the top.
   always_comb begin
      dx = a_sh[7:0];
      dy = b_sh[7:0];
      if (state == NEG) begin
         dx = 8'h00;
         dy = res_sh[7:0];
      end
   end

   bcd_sub_digit2 u_digit (
      .a    (dx),
      .b    (dy),
      .bin  (brw),
      .o    (dig_o),
      .bout (dig_bout)
   );

   assign res_next = (res_sh >> 8) | (W'(dig_o) << (W - 8));
   assign last     = (cnt == CW'(N - 1));
   assign busy     = (state != IDLE);

   always_comb begin
      ld_err = 1'b0;
      for (int i = 0; i < 2 * N; i++) begin
         if (!bcd_digit_valid(a[4*i +: 4]) || !bcd_digit_valid(b[4*i +: 4]))
            ld_err = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         brw    <= 1'b0;
         sm_q   <= 1'b0;
         cnt    <= '0;
         o      <= '0;
         bo     <= 1'b0;
         neg    <= 1'b0;
         err    <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (ld) begin
                  a_sh   <= a;
                  b_sh   <= b;
                  res_sh <= '0;
                  brw    <= bi;
                  sm_q   <= sm;
                  err    <= ld_err;
                  cnt    <= '0;
                  bo     <= 1'b0;
                  neg    <= 1'b0;
                  state  <= SUB;
               end
            end
            SUB: begin
               res_sh <= res_next;
               a_sh   <= a_sh >> 8;
               b_sh   <= b_sh >> 8;
               brw    <= dig_bout;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  bo <= dig_bout;
                  if (sm_q && dig_bout) begin
                     state <= NEG;
                     cnt   <= '0;
                     brw   <= 1'b0;
                  end else begin
                     state <= IDLE;
                     done  <= 1'b1;
                     o     <= res_next;
                  end
               end
            end
            NEG: begin
               res_sh <= res_next;
               brw    <= dig_bout;
               cnt    <= cnt + 1'b1;
               if (last) begin
                  neg   <= 1'b1;
                  state <= IDLE;
                  done  <= 1'b1;
                  o     <= res_next;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_sub_seq.sv
module tb_bcd_sub_seq;

   localparam int N = 4;
   localparam int W = N * 8;

   logic         clk;
   logic         rst;
   logic         ld;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bi;
   logic         sm;
   logic [W-1:0] o;
   logic         bo;
   logic         neg;
   logic         err;
   logic         busy;
   logic         done;

   int checks;
   int failures;
   int cyc;
   logic busy_all;

   bcd_sub_seq #(.N(N)) dut (
      .clk  (clk),
      .rst  (rst),
      .ld   (ld),
      .a    (a),
      .b    (b),
      .bi   (bi),
      .sm   (sm),
      .o    (o),
      .bo   (bo),
      .neg  (neg),
      .err  (err),
      .busy (busy),
      .done (done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // drive one ld pulse; returns just after the edge that samples it
   task automatic start(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic biv, input logic smv);
      a  = av;
      b  = bv;
      bi = biv;
      sm = smv;
      ld = 1'b1;
      step();
      ld = 1'b0;
   endtask

   // count edges until done, bounded; busy_all tracks busy before done
   task automatic wait_done(output int n);
      n = 0;
      busy_all = busy;
      while (!done && n < 40) begin
         step();
         n++;
         if (!done) busy_all = busy_all & busy;
      end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst = 1'b1;
      ld  = 1'b0;
      a   = '0;
      b   = '0;
      bi  = 1'b0;
      sm  = 1'b0;
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_o",    64'(o),    64'd0);
      chk("rst_flags", {61'd0, bo, neg, err}, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // 42 - 17
      start(32'h00000042, 32'h00000017, 1'b0, 1'b0);
      wait_done(cyc);
      chk("t1_lat", 64'(cyc), 64'd4);
      chk("t1_o",   64'(o),   64'h00000025);
      chk("t1_flags", {61'd0, bo, neg, err}, 64'd0);

      // 17 - 42, raw ten's complement
      start(32'h00000017, 32'h00000042, 1'b0, 1'b0);
      wait_done(cyc);
      chk("t2_lat", 64'(cyc), 64'd4);
      chk("t2_o",   64'(o),   64'h99999975);
      chk("t2_bo",  64'(bo),  64'd1);
      chk("t2_neg", 64'(neg), 64'd0);

      // 17 - 42, sign-magnitude
      start(32'h00000017, 32'h00000042, 1'b0, 1'b1);
      wait_done(cyc);
      chk("t3_lat",  64'(cyc), 64'd8);
      chk("t3_busy", 64'(busy_all), 64'd1);
      chk("t3_o",    64'(o),   64'h00000025);
      chk("t3_bo",   64'(bo),  64'd1);
      chk("t3_neg",  64'(neg), 64'd1);
      step();
      chk("t3_done_pulse", 64'(done), 64'd0);

      // borrow in ripples through a zero digit
      start(32'h00000100, 32'h00000000, 1'b1, 1'b0);
      wait_done(cyc);
      chk("t4_o",  64'(o),  64'h00000099);
      chk("t4_bo", 64'(bo), 64'd0);

      // illegal digit: flag only
      start(32'h0000000A, 32'h00000001, 1'b0, 1'b0);
      wait_done(cyc);
      chk("t5_lat", 64'(cyc), 64'd4);
      chk("t5_err", 64'(err), 64'd1);
      chk("t5_o",   64'(o),   64'h00000009);

      // a = b, sm=1: zero, no negation; err cleared by new ld
      start(32'h12345678, 32'h12345678, 1'b0, 1'b1);
      wait_done(cyc);
      chk("t6_lat", 64'(cyc), 64'd4);
      chk("t6_o",   64'(o),   64'h00000000);
      chk("t6_flags", {61'd0, bo, neg, err}, 64'd0);

      // 0 - 0 - 1 with sign-magnitude
      start(32'h00000000, 32'h00000000, 1'b1, 1'b1);
      wait_done(cyc);
      chk("t7_lat", 64'(cyc), 64'd8);
      chk("t7_o",   64'(o),   64'h00000001);
      chk("t7_bo",  64'(bo),  64'd1);
      chk("t7_neg", 64'(neg), 64'd1);

      // async reset in the middle of SUB
      start(32'h00000042, 32'h00000017, 1'b0, 1'b0);
      step();
      step();
      chk("t8_busy_pre", 64'(busy), 64'd1);
      rst = 1'b1;
      #1;
      chk("t8_busy", 64'(busy), 64'd0);
      chk("t8_done", 64'(done), 64'd0);
      chk("t8_o",    64'(o),    64'd0);
      chk("t8_bo",   64'(bo),   64'd0);
      @(negedge clk);
      rst = 1'b0;
      step();

      // normal run after reset
      start(32'h00005000, 32'h00001234, 1'b0, 1'b0);
      wait_done(cyc);
      chk("t9_lat", 64'(cyc), 64'd4);
      chk("t9_o",   64'(o),   64'h00003766);

      // ld while busy is ignored
      start(32'h00000050, 32'h00000020, 1'b0, 1'b0);
      step();
      a  = 32'h00000099;
      b  = 32'h00000011;
      ld = 1'b1;
      step();
      ld = 1'b0;
      wait_done(cyc);
      chk("t10_lat", 64'(cyc), 64'd2);
      chk("t10_o",   64'(o),   64'h00000030);
      step();
      chk("t10_idle", 64'(busy), 64'd0);

      // back-to-back: ld in the done cycle
      start(32'h00000081, 32'h00000009, 1'b0, 1'b0);
      wait_done(cyc);
      chk("t11a_o", 64'(o), 64'h00000072);
      start(32'h00000300, 32'h00000001, 1'b0, 1'b0);
      wait_done(cyc);
      chk("t11b_lat", 64'(cyc), 64'd4);
      chk("t11b_o",   64'(o),   64'h00000299);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_sub_seq.md
Name: bcd_sub_seq

Overview:
Byte-serial packed-BCD subtractor: computes a - b - bi over N bytes (2N digits), two digits per clock.
- Optionally converts a negative ten's-complement result to sign-magnitude with a second serial pass.
- Companion to the pipelined BCD adder in the decimal FPU datapath; used for significand subtraction where area matters more than latency.
- Start/done handshake toward the DFPU sequencer.

Parameters:
N, 33, operand width in bytes (2N BCD digits), matching the adder's N.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
ld  in  1  start request; accepted only when busy=0
a  in  N*8  minuend, packed BCD, sampled on accepted ld
b  in  N*8  subtrahend, packed BCD, sampled on accepted ld
bi  in  1  borrow in, sampled on accepted ld
sm  in  1  1 = sign-magnitude result, 0 = raw ten's complement; sampled on accepted ld
o  out  N*8  difference; valid while done=1 and held until the next accepted ld
bo  out  1  borrow out of the top digit after the SUB pass
neg  out  1  1 when sm=1 and the result was negated
err  out  1  some digit of a or b was >9 at ld; flag only, computation proceeds
busy  out  1  state != IDLE
done  out  1  one-cycle pulse: result valid

Behaviour:
- Reset (async, any time including mid-operation): state=IDLE. o, bo, neg, err, done, internal shift registers, byte counter and borrow flop all 0.
- States: IDLE, SUB, NEG.
- IDLE:
  - ld=1 at a clock edge: load a, b into shift registers; borrow flop<=bi; latch sm; err<=any nibble of a or b >9; cnt<=0; bo, neg<=0; state->SUB.
  - ld while busy=1 is ignored.
  - ld in the same cycle done=1 is accepted.
- SUB, one byte per edge, low byte first:
  - bcd_sub_digit2 computes a[7:0] - b[7:0] - borrow.
  - Each digit: d = x - y - bin; if d<0 then d += 10 and bout=1.
  - Byte result is shifted in at the top of the result register; a and b shift right 8; borrow flop <= byte bout; cnt++.
  - At cnt=N-1: bo<=bout.
    - If sm=1 and bout=1: state->NEG, cnt<=0, borrow<=0.
    - Otherwise state->IDLE, done pulses.
- NEG: same serial datapath with minuend 0 and subtrahend = result register byte (ten's complement back to magnitude). After N bytes: neg<=1, state->IDLE, done pulses.
- Latency, ld sampled at edge k:
  - Without negation, done=1 after edge k+N.
  - With negation, done=1 after edge k+2N.
  - Throughput: one operation per N+1 (or 2N+1) cycles.
- Boundary cases:
  - a=b with bi=0 gives o=0, bo=0, neg=0.
  - a=0, b=0, bi=1, sm=1 gives the magnitude 0...01 with neg=1.
  - Invalid digits: arithmetic is still applied nibble-wise by the formula above (result undefined but deterministic); err stays set until the next ld.
  - o is not updated combinationally during SUB/NEG: shift holds partial results, and o copies the completed register when done asserts.

Decomposition:
- bcd_pkg:
  - typedef enum {IDLE, SUB, NEG} bcd_sub_state_t;
  - constants BCD_DIGIT_MAX=9, BCD_RADIX=10;
  - function bcd_digit_valid(nibble).
- One combinational sub-module, bcd_sub_digit2: 8-bit packed a, b, bin -> 8-bit o, bout. It is reused for both the SUB and NEG passes.
- State register, counter, shift registers and output registers live in bcd_sub_seq.

Test Plan (N=4):
- a=0x00000042, b=0x00000017, bi=0, sm=0, ld pulse -> done exactly 4 cycles later; o=0x00000025, bo=0, neg=0, err=0.
- a=0x00000017, b=0x00000042, sm=0 -> o=0x99999975, bo=1, neg=0, done at +4.
- Same operands with sm=1 -> o=0x00000025, bo=1, neg=1, done at +8; busy high throughout cycles 1..8.
- a=0x00000100, b=0, bi=1, sm=0 -> o=0x00000099, bo=0.
- a=0x0000000A, b=0x00000001 -> err=1, done still at +4.
- rst asserted mid-SUB (cycle 2) -> busy, done, o, bo all 0 immediately. A ld after reset runs normally; ld pulses during busy are ignored; back-to-back ld in the done cycle is accepted.
